// File: rtl/tinyml_hw_accel_out_stream_buffer.sv
// tinyml_hw_accel_out_stream_buffer
//   Buffers the packer's 32-bit words (which arrive without backpressure) in a FIFO and
//   presents them as a ready/valid stream with a frame-end marker to the DMA write channel.
//   Words that arrive while the buffer is full are dropped and flagged by a sticky overflow bit.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_data/valid   incoming packed word (no ready: written or dropped)
//   out_data/valid  output stream, out_ready from DMA, out_last marks word FRAME_WORDS-1
//   fifo_level      entries held (RAM storage plus output register), 0..FIFO_DEPTH
//   overflow        sticky drop flag, cleared by overflow_clr (a new drop wins)
//   frame_count     (only with TINYML_OBUF_FRAME_COUNT_EN) frames delivered, wraps at 16 bits
//
// Build option: define TINYML_OBUF_FRAME_COUNT_EN to add the frame_count output.

`timescale 1ns/1ps

module tinyml_hw_accel_out_stream_buffer #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned FIFO_DEPTH  = 512,
   parameter int unsigned FRAME_WORDS = 6912
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic                          in_valid,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_last,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          overflow_clr
`ifdef TINYML_OBUF_FRAME_COUNT_EN
   ,
   output logic [15:0]                   frame_count
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned EW = DATA_WIDTH + 1;
   localparam int unsigned CW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

   // Storage entry is {last_tag, data}
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [EW-1:0] ram_q;
   logic [EW-1:0] wr_entry;

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_addr;
   logic [LW-1:0] ram_cnt;
   logic [CW-1:0] word_cnt;

   logic full;
   logic pop;
   logic wr_en;
   logic drop;
   logic last_tag;
   logic out_free;
   logic ram_pop;
   logic bypass;
   logic ram_we;

   // Write/drop/pop decisions; full is taken before the same-cycle pop
   always_comb begin
      full     = (fifo_level == LW'(FIFO_DEPTH));
      pop      = out_valid & out_ready;
      wr_en    = in_valid & (~full | pop);
      drop     = in_valid & full & ~pop;
      last_tag = (word_cnt == CW'(FRAME_WORDS - 1));
      wr_entry = {last_tag, in_data};
      // Output register can take a new word when empty or being emptied this cycle
      out_free = ~out_valid | pop;
      ram_pop  = out_free & (ram_cnt != '0);
      // With no stored words, an incoming word goes straight to the output register
      bypass   = out_free & (ram_cnt == '0) & wr_en;
      ram_we   = wr_en & ~bypass;
      rd_addr  = ram_pop ? (rd_ptr + AW'(1)) : rd_ptr;
   end

   // Simple dual-port RAM, write port
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // Registered read that always holds the entry at the next read pointer;
   // a same-cycle write to that address is forwarded so ram_q is never stale
   always_ff @(posedge clk) begin
      if (ram_we && (wr_ptr == rd_addr)) begin
         ram_q <= wr_entry;
      end else begin
         ram_q <= mem[rd_addr];
      end
   end

   // Pointers, counters, output register and status
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         ram_cnt    <= '0;
         word_cnt   <= '0;
         fifo_level <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
         overflow   <= 1'b0;
      end else begin
         // Frame grid follows every upstream word, dropped or not
         if (in_valid) begin
            word_cnt <= last_tag ? '0 : (word_cnt + CW'(1));
         end

         if (ram_we) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (ram_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end

         if (ram_we && !ram_pop) begin
            ram_cnt <= ram_cnt + LW'(1);
         end else if (ram_pop && !ram_we) begin
            ram_cnt <= ram_cnt - LW'(1);
         end

         if (wr_en && !pop) begin
            fifo_level <= fifo_level + LW'(1);
         end else if (pop && !wr_en) begin
            fifo_level <= fifo_level - LW'(1);
         end

         if (ram_pop) begin
            {out_last, out_data} <= ram_q;
            out_valid            <= 1'b1;
         end else if (bypass) begin
            {out_last, out_data} <= wr_entry;
            out_valid            <= 1'b1;
         end else if (pop) begin
            out_valid <= 1'b0;
         end

         if (drop) begin
            overflow <= 1'b1;
         end else if (overflow_clr) begin
            overflow <= 1'b0;
         end
      end
   end

`ifdef TINYML_OBUF_FRAME_COUNT_EN
   // Counts delivered frame-end words
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_count <= '0;
      end else if (pop && out_last) begin
         frame_count <= frame_count + 16'(1);
      end
   end
`endif

endmodule
